// File: rtl/pipelined_addsub.sv
// Carry-slice pipelined adder/subtractor: one W-bit slice per stage with the carry registered
// between stages, and a single global advance providing ready/valid backpressure.
module pipelined_addsub #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int S = (STAGES < 1) ? 1 : STAGES;
  localparam int W = N / S;

  if ((STAGES < 1) || ((N % S) != 0)) begin : g_bad_cfg
    $error("pipelined_addsub: STAGES must be >= 1 and divide N");
  end

  // Each stage carries full-width operand and partial-sum registers; untouched slices ride along skewed.
  logic [N-1:0] a_q [S];
  logic [N-1:0] b_q [S];
  logic [N-1:0] s_q [S];
  logic         c_q [S];
  logic         v_q [S];
  logic [N-1:0] a_d [S];
  logic [N-1:0] b_d [S];
  logic [N-1:0] s_d [S];
  logic         c_d [S];
  logic         v_d [S];

  logic [N-1:0] ai, bi, si;
  logic         ci, vi;
  logic [W:0]   part;
  logic         ovf_d, zero_d, ovf_q, zero_q;
  logic         advance;

  assign advance   = !v_q[S-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[S-1];
  assign sum       = s_q[S-1];
  assign cout      = c_q[S-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    ai   = '0;
    bi   = '0;
    si   = '0;
    ci   = 1'b0;
    vi   = 1'b0;
    part = '0;
    for (int unsigned k = 0; k < S; k++) begin
      if (k == 0) begin
        ai = a;
        bi = sub ? ~b : b;
        si = '0;
        ci = sub;
        vi = in_valid;
      end else begin
        ai = a_q[k-1];
        bi = b_q[k-1];
        si = s_q[k-1];
        ci = c_q[k-1];
        vi = v_q[k-1];
      end
      part = {1'b0, ai[k*W +: W]} + {1'b0, bi[k*W +: W]} + {{W{1'b0}}, ci};
      a_d[k] = ai;
      b_d[k] = bi;
      s_d[k] = si;
      s_d[k][k*W +: W] = part[W-1:0];
      c_d[k] = part[W];
      v_d[k] = vi;
    end
    ovf_d  = (a_d[S-1][N-1] == b_d[S-1][N-1]) && (s_d[S-1][N-1] != a_d[S-1][N-1]);
    zero_d = (s_d[S-1] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < S; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < S; k++) begin
        v_q[k] <= v_d[k];
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_d[S-1]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: three configurations (8/2, 8/1, 32/4) checked
// against an arithmetic reference model, with backpressure, bubbles and mid-flight reset.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v8, rdy8, sub8, ov8, ordy8, c8, o8, z8;
  logic [7:0] a8, b8, s8;
  logic       v1, rdy1, sub1, ov1, ordy1, c1, o1, z1;
  logic [7:0] a1, b1, s1;
  logic        v32, rdy32, sub32, ov32, ordy32, c32, o32, z32;
  logic [31:0] a32, b32, s32;

  pipelined_addsub #(.N(8), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(ov8), .out_ready(ordy8), .sum(s8), .cout(c8), .ovf(o8), .zero(z8));
  pipelined_addsub #(.N(8), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1), .sub(sub1),
    .out_valid(ov1), .out_ready(ordy1), .sum(s1), .cout(c1), .ovf(o1), .zero(z1));
  pipelined_addsub #(.N(32), .STAGES(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .a(a32), .b(b32), .sub(sub32),
    .out_valid(ov32), .out_ready(ordy32), .sum(s32), .cout(c32), .ovf(o32), .zero(z32));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {ovf, zero, cout, sum} from plain integer arithmetic.
  function automatic logic [34:0] ref_model(input int n, input longint x, input longint y, input bit s);
    longint m, r, lim, sx, sy, sr;
    bit c, v;
    m   = (longint'(1) << n) - 1;
    lim = longint'(1) << (n - 1);
    x = x & m;
    y = y & m;
    if (s) begin
      r = (x - y) & m;
      c = (x >= y);
    end else begin
      r = x + y;
      c = (r > m);
      r = r & m;
    end
    sx = (x >= lim) ? x - 2 * lim : x;
    sy = (y >= lim) ? y - 2 * lim : y;
    sr = s ? sx - sy : sx + sy;
    v  = (sr >= lim) || (sr < -lim);
    return {v, (r == 0), c, 32'(r)};
  endfunction

  logic [34:0] qe8[$], qe1[$], qe32[$];
  int          qc8[$], qc1[$], qc32[$];
  bit          lat8 = 1'b1, lat1 = 1'b1, lat32 = 1'b1;

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int t = 0;
    a8 = x; b8 = y; sub8 = s; v8 = 1'b1;
    @(negedge clk);
    while (!rdy8 && t < 100) begin t++; @(negedge clk); end
    if (!rdy8) chk("issue8_timeout", 0, 1);
    else begin qe8.push_back(ref_model(8, longint'(x), longint'(y), s)); qc8.push_back(cyc); end
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic issue1(input logic [7:0] x, input logic [7:0] y, input logic s);
    int t = 0;
    a1 = x; b1 = y; sub1 = s; v1 = 1'b1;
    @(negedge clk);
    while (!rdy1 && t < 100) begin t++; @(negedge clk); end
    if (!rdy1) chk("issue1_timeout", 0, 1);
    else begin qe1.push_back(ref_model(8, longint'(x), longint'(y), s)); qc1.push_back(cyc); end
    @(posedge clk); #1;
    v1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); sub1 = 1'($urandom);
  endtask

  task automatic issue32(input logic [31:0] x, input logic [31:0] y, input logic s);
    int t = 0;
    a32 = x; b32 = y; sub32 = s; v32 = 1'b1;
    @(negedge clk);
    while (!rdy32 && t < 100) begin t++; @(negedge clk); end
    if (!rdy32) chk("issue32_timeout", 0, 1);
    else begin qe32.push_back(ref_model(32, longint'(x), longint'(y), s)); qc32.push_back(cyc); end
    @(posedge clk); #1;
    v32 = 1'b0; a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
  endtask

  // Monitors: pop on each output transfer; while stalled, outputs must hold and in_ready must be low.
  logic [34:0] hold8, hold1, hold32, e8, e1, e32;
  bit          held8 = 1'b0, held1 = 1'b0, held32 = 1'b0;

  always @(negedge clk) begin
    if (rst) held8 = 1'b0;
    else begin
      if (held8) chk("stable8", {ov8, o8, z8, c8, 24'h0, s8}, {1'b1, hold8});
      if (ov8 && ordy8) begin
        if (qe8.size() == 0) chk("spurious8", 1, 0);
        else begin
          e8 = qe8.pop_front();
          chk("result8", {o8, z8, c8, 24'h0, s8}, e8);
          if (lat8) chk("latency8", 64'(cyc - qc8.pop_front()), 2);
          else void'(qc8.pop_front());
        end
      end
      held8 = ov8 && !ordy8;
      hold8 = {o8, z8, c8, 24'h0, s8};
      if (held8) chk("stall_ready8", rdy8, 0);
    end
  end

  always @(negedge clk) begin
    if (rst) held1 = 1'b0;
    else begin
      if (held1) chk("stable1", {ov1, o1, z1, c1, 24'h0, s1}, {1'b1, hold1});
      if (ov1 && ordy1) begin
        if (qe1.size() == 0) chk("spurious1", 1, 0);
        else begin
          e1 = qe1.pop_front();
          chk("result1", {o1, z1, c1, 24'h0, s1}, e1);
          if (lat1) chk("latency1", 64'(cyc - qc1.pop_front()), 1);
          else void'(qc1.pop_front());
        end
      end
      held1 = ov1 && !ordy1;
      hold1 = {o1, z1, c1, 24'h0, s1};
    end
  end

  always @(negedge clk) begin
    if (rst) held32 = 1'b0;
    else begin
      if (held32) chk("stable32", {ov32, o32, z32, c32, s32}, {1'b1, hold32});
      if (ov32 && ordy32) begin
        if (qe32.size() == 0) chk("spurious32", 1, 0);
        else begin
          e32 = qe32.pop_front();
          chk("result32", {o32, z32, c32, s32}, e32);
          if (lat32) chk("latency32", 64'(cyc - qc32.pop_front()), 4);
          else void'(qc32.pop_front());
        end
      end
      held32 = ov32 && !ordy32;
      hold32 = {o32, z32, c32, s32};
      if (held32) chk("stall_ready32", rdy32, 0);
    end
  end

  task automatic drain();
    int t = 0;
    while ((qe8.size() + qe1.size() + qe32.size()) != 0 && t < 500) begin
      @(posedge clk); t++;
    end
    chk("drain_pending", 64'(qe8.size() + qe1.size() + qe32.size()), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  t_start;
  bit  done32;

  initial begin
    rst = 1'b1;
    v8 = 0; a8 = 0; b8 = 0; sub8 = 0; ordy8 = 1;
    v1 = 0; a1 = 0; b1 = 0; sub1 = 0; ordy1 = 1;
    v32 = 0; a32 = 0; b32 = 0; sub32 = 0; ordy32 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid8", ov8, 0);
    chk("reset_in_ready8", rdy8, 1);
    chk("reset_outputs8", {s8, c8, o8, z8}, 0);
    chk("reset_out_valid32", ov32, 0);
    chk("reset_in_ready32", rdy32, 1);
    chk("reset_outputs1", {ov1, s1, c1, o1, z1}, 0);
    rst = 1'b0;

    // Accepted on the first edge after reset release.
    issue8(8'hFF, 8'h01, 1'b0);
    issue8(8'h05, 8'h07, 1'b1);
    issue8(8'h7F, 8'h01, 1'b0);
    issue8(8'h80, 8'h01, 1'b1);
    issue8(8'h00, 8'h00, 1'b1);
    issue1(8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 20; i++) issue1(8'($urandom), 8'($urandom), 1'($urandom));
    drain();

    // Backpressure: three ops while the consumer stalls.
    lat8 = 1'b0;
    ordy8 = 1'b0;
    fork
      begin
        issue8(8'h11, 8'h22, 1'b0);
        issue8(8'h33, 8'h44, 1'b1);
        issue8(8'hF0, 8'h0F, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("stall_out_valid8", ov8, 1);
        chk("stall_in_ready8", rdy8, 0);
        ordy8 = 1'b1;
      end
    join
    drain();
    lat8 = 1'b1;

    // Reset with two ops in flight.
    issue8(8'h12, 8'h34, 1'b0);
    issue8(8'h56, 8'h78, 1'b1);
    chk("preflush_out_valid8", ov8, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid8", ov8, 0);
    chk("async_reset_sum8", {s8, c8, o8, z8}, 0);
    qe8.delete(); qc8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue8(8'h10, 8'h20, 1'b0);
    drain();

    // Back-to-back random traffic on the 32-bit, 4-stage pipe.
    t_start = cyc;
    for (int i = 0; i < 100; i++) issue32($urandom, $urandom, 1'($urandom));
    chk("throughput32_cycles", 64'(cyc - t_start), 100);
    drain();

    // Random bubbles and random consumer stalls.
    lat32 = 1'b0;
    done32 = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          issue32($urandom, $urandom, 1'($urandom));
        end
        done32 = 1'b1;
      end
      begin
        while (!done32) begin
          @(posedge clk); #1;
          ordy32 = 1'($urandom);
        end
        ordy32 = 1'b1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 SHALL have parameter N, default 32, operand width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline stages; N/STAGES bits are summed per stage.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand set present this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port a, input, N, operand A (two's complement or unsigned).
REQ-008 SHALL have port b, input, N, operand B.
REQ-009 SHALL have port sub, input, 1, 0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result this cycle.
REQ-012 SHALL have port sum, output, N, result bits [N-1:0].
REQ-013 SHALL have port cout, output, 1, carry out of bit N-1 (for subtract: 1 = no borrow).
REQ-014 SHALL have port ovf, output, 1, signed overflow.
REQ-015 SHALL have port zero, output, 1, sum == 0.

Function
REQ-016 SHALL reject at elaboration any configuration with STAGES < 1 or N not divisible by STAGES.
REQ-017 SHALL transfer input when in_valid && in_ready at a rising edge, output when out_valid && out_ready.
REQ-018 SHALL compute subtract as a + ~b + 1: b inverted at capture, carry-in of slice 0 = sub.
REQ-019 SHALL sum slice k (bits [(k+1)W-1:kW], W=N/STAGES) in stage k using the carry registered out of stage k-1; unconsumed upper operand slices and finished lower sum slices SHALL travel skewed with the token.
REQ-020 SHALL use a global advance = !out_valid || out_ready; every stage register and its valid bit loads only when advance is 1.
REQ-021 SHALL drive in_ready = advance (combinational from out_valid, out_ready; never from in_valid).
REQ-022 SHALL present a result STAGES cycles after acceptance when out_ready is held 1 (STAGES=1: one-cycle registered latency).
REQ-023 SHALL sustain throughput of one operation per cycle with out_ready held 1.
REQ-024 SHALL hold sum, cout, ovf, zero and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL propagate bubbles (in_valid=0 while advancing) as invalid tokens; results leave in acceptance order with none dropped or duplicated.
REQ-026 SHALL compute ovf = (a[N-1] == b'[N-1]) && (sum[N-1] != a[N-1]), where b' is b after optional inversion.
REQ-027 SHALL compute cout and zero in the final stage from the fully assembled result.
REQ-028 SHALL ignore a, b, sub when the transfer condition of REQ-017 is false.

Reset
REQ-029 SHALL, while rst is high, force all stage valid bits, out_valid, sum, cout, ovf, zero to 0 immediately, independent of clk.
REQ-030 SHALL drive in_ready = 1 during and after reset (pipeline empty).
REQ-031 SHALL discard all in-flight operations on reset; no result from before reset ever appears afterward.
REQ-032 SHALL accept a new operation on the first rising edge after rst deasserts.

Verification
REQ-033 N=8, STAGES=2, out_ready=1: a=0xFF, b=0x01, sub=0 -> after 2 cycles sum=0x00, cout=1, zero=1, ovf=0.
REQ-034 N=8, STAGES=2: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0, zero=0; a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1, cout=0.
REQ-035 N=32, STAGES=4: 100 random back-to-back ops, out_ready=1 -> one result per cycle from cycle 4, all match reference a±b.
REQ-036 N=8, STAGES=2: 3 ops issued, out_ready=0 for 4 cycles -> out_valid=1 with first result held stable, in_ready=0 once the pipeline holds a result, then out_ready=1 -> 3 results in order, none lost.
REQ-037 N=8, STAGES=2: reset pulse with 2 ops in flight -> out_valid=0 immediately, no stale result after release, new op a=0x10, b=0x20 -> sum=0x30 after 2 cycles.
REQ-038 N=8, STAGES=1: a=0x80, b=0x80, sub=0 -> next cycle sum=0x00, cout=1, ovf=1, zero=1.
